// File: rtl/iob_eth_dma_pkg.sv
// Shared constants and types for the Ethernet DMA engines: fixed AXI read
// attributes, FSM state encoding and the TX buffer last-word strobe helper.
package iob_eth_dma_pkg;

    localparam logic [2:0] AXI_SIZE_W32   = 3'h2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'h2;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b010;
    localparam int         BUF_BASE_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Byte enables of the final buffer word, from the low two bits of the length.
    function automatic logic [3:0] last_wstrb(input logic [1:0] len_lo);
        logic [3:0] s;
        case (len_lo)
            2'd1:    s = 4'h1;
            2'd2:    s = 4'h3;
            2'd3:    s = 4'h7;
            default: s = 4'hF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/eth_burst_merge.sv
// Realigns AXI read beats to buffer words: keeps the previous beat and splices
// its upper bytes with the lower bytes of the current beat (or zeros on flush).
module eth_burst_merge
    import iob_eth_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beat_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic        flush_i,
    input  logic        last_i,
    input  logic [1:0]  len_lo_i,
    output logic [31:0] word_o,
    output logic [3:0]  wstrb_o
);

    logic [31:0] prev_q;
    logic [31:0] cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (beat_i) begin
            prev_q <= rdata_i;
        end
    end

    always_comb begin
        cur     = flush_i ? 32'h0 : rdata_i;
        word_o  = cur;
        case (off_i)
            2'd1:    word_o = {cur[7:0],  prev_q[31:8]};
            2'd2:    word_o = {cur[15:0], prev_q[31:16]};
            2'd3:    word_o = {cur[23:0], prev_q[31:24]};
            default: word_o = cur;
        endcase
        wstrb_o = last_i ? last_wstrb(len_lo_i) : 4'hF;
    end

endmodule

// File: rtl/iob_eth_dma_r.sv
// AXI4 read DMA for the Ethernet TX path: one INCR burst from memory, realigned
// to byte 0 and written into the TX frame buffer starting at BUF_BASE.
module iob_eth_dma_r
    import iob_eth_dma_pkg::*;
#(
    parameter int DMA_DATA_W = 32,
    parameter int AXI_ADDR_W = 32,
    parameter int BUF_BASE   = BUF_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    output logic                  m_axi_arid,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DMA_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    input  logic [AXI_ADDR_W-1:0] dma_addr,
    input  logic [9:0]            dma_len,
    input  logic                  dma_run,
    output logic                  dma_ready,
    output logic                  dma_error,

    output logic [DMA_DATA_W-1:0] in_data,
    output logic [8:0]            in_addr,
    output logic [3:0]            in_wstrb,
    output logic                  in_wr
);

    state_t state_q, state_d;

    logic [1:0]            off_q;
    logic [1:0]            len_lo_q;
    logic [8:0]            nbeats_q, bcnt_q;
    logic [8:0]            nwords_q, wcnt_q;
    logic                  flush_q;
    logic [AXI_ADDR_W-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic                  err_q;
    logic                  in_wr_q;
    logic [31:0]           in_data_q;
    logic [8:0]            in_addr_q, waddr_q;
    logic [3:0]            in_wstrb_q;

    logic        start, beat, last_beat, wr_d, wlast, flush_sel;
    logic [8:0]  nb, nw;
    logic [31:0] mword;
    logic [3:0]  mstrb;
    logic        unused_rlast;

    // Burst length is fixed up front from the beat count, so rlast carries no information.
    assign unused_rlast = m_axi_rlast;

    assign start     = dma_run && (dma_len != 10'd0);
    assign nb        = 9'((11'(dma_len) + 11'(dma_addr[1:0]) + 11'd3) >> 2);
    assign nw        = 9'((11'(dma_len) + 11'd3) >> 2);
    assign beat      = (state_q == ST_DATA) && m_axi_rvalid;
    assign last_beat = beat && (bcnt_q == nbeats_q - 9'd1);
    assign wlast     = (wcnt_q == nwords_q - 9'd1);

    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        flush_sel = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ADDR;
            ST_ADDR:  if (m_axi_arready) state_d = ST_DATA;
            ST_DATA: begin
                // Unaligned: beat 0 only primes the merge register.
                if (beat) wr_d = (off_q == 2'd0) || (bcnt_q != 9'd0);
                if (last_beat) state_d = flush_q ? ST_FLUSH : ST_DONE;
            end
            ST_FLUSH: begin
                wr_d      = 1'b1;
                flush_sel = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    eth_burst_merge u_merge (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat_i   (beat),
        .rdata_i  (m_axi_rdata),
        .off_i    (off_q),
        .flush_i  (flush_sel),
        .last_i   (wlast),
        .len_lo_i (len_lo_q),
        .word_o   (mword),
        .wstrb_o  (mstrb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            len_lo_q   <= '0;
            nbeats_q   <= '0;
            bcnt_q     <= '0;
            nwords_q   <= '0;
            wcnt_q     <= '0;
            flush_q    <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            err_q      <= 1'b0;
            in_wr_q    <= 1'b0;
            in_data_q  <= '0;
            in_addr_q  <= '0;
            waddr_q    <= '0;
            in_wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                off_q    <= dma_addr[1:0];
                len_lo_q <= dma_len[1:0];
                nbeats_q <= nb;
                nwords_q <= nw;
                // The last word sits wholly in the last beat only when words == beats.
                flush_q  <= (dma_addr[1:0] != 2'd0) && (nb == nw);
                araddr_q <= {dma_addr[AXI_ADDR_W-1:2], 2'b00};
                arlen_q  <= 8'(nb - 9'd1);
                err_q    <= 1'b0;
                bcnt_q   <= '0;
                wcnt_q   <= '0;
                waddr_q  <= 9'(BUF_BASE);
            end
            if (beat) begin
                bcnt_q <= bcnt_q + 9'd1;
                if (m_axi_rresp != 2'b00) err_q <= 1'b1;
            end
            in_wr_q <= wr_d;
            if (wr_d) begin
                in_data_q  <= mword;
                in_wstrb_q <= mstrb;
                in_addr_q  <= waddr_q;
                waddr_q    <= waddr_q + 9'd1;
                wcnt_q     <= wcnt_q + 9'd1;
            end
        end
    end

    assign m_axi_arid    = 1'b0;
    assign m_axi_arsize  = AXI_SIZE_W32;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_MOD;
    assign m_axi_arprot  = AXI_PROT_DATA;
    assign m_axi_arqos   = 4'h0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = (state_q == ST_ADDR);
    assign m_axi_rready  = (state_q == ST_DATA);
    assign dma_ready     = (state_q == ST_IDLE);
    assign dma_error     = err_q;
    assign in_data       = in_data_q;
    assign in_addr       = in_addr_q;
    assign in_wstrb      = in_wstrb_q;
    assign in_wr         = in_wr_q;

endmodule
